sonic_sysid_checker: RTL and testbench

- Avalon-MM read master sitting directly upstream of the NIOS-base system-ID slave.
- After reset, it reads the ID word (address 0) and the timestamp word (address 1), then compares them against build-time expectations.
- It raises a sticky pass/fail result that gates transceiver bring-up logic and is mirrored into a status CSR.
- It retries a bounded number of times before declaring failure.

---
 rtl/sonic_sysid_pkg.sv | 9 +
 rtl/sonic_sysid_rd_timer.sv | 19 +
 rtl/sonic_sysid_checker.sv | 132 +++++++++++++
 tb/tb_sonic_sysid_checker.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/sonic_sysid_pkg.sv
// sonic_sysid_pkg: FSM states, Avalon addresses and the default ID for the system-ID checker.
package sonic_sysid_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_RD_ID, S_WAIT_ID, S_RD_TS, S_WAIT_TS, S_CHECK, S_GAP, S_DONE
  } state_t;
  localparam logic        SYSID_ADDR_ID     = 1'b0;
  localparam logic        SYSID_ADDR_TS     = 1'b1;
  localparam logic [31:0] SYSID_EXPECTED_ID = 32'h38D8FF5B;
endpackage

// File: rtl/sonic_sysid_rd_timer.sv
// sonic_sysid_rd_timer: loadable 8-bit down-counter that stops at zero and flags it.
module sonic_sysid_rd_timer (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_load,
  input  logic [7:0] i_value,
  input  logic       i_dec,
  output logic [7:0] o_count,
  output logic       o_zero
);
  logic [7:0] r_count;
  always_ff @(posedge clock) begin
    if (reset) r_count <= '0;
    else if (i_load) r_count <= i_value;
    else if (i_dec && r_count != 8'd0) r_count <= r_count - 8'd1;
  end
  assign o_count = r_count;
  assign o_zero  = r_count == 8'd0;
endmodule

// File: rtl/sonic_sysid_checker.sv
// sonic_sysid_checker: reads the system-ID slave after reset and latches a sticky pass/fail verdict.
module sonic_sysid_checker
  import sonic_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID   = SYSID_EXPECTED_ID,
  parameter logic [31:0] MIN_TIMESTAMP = 32'd0,
  parameter int unsigned READ_LATENCY  = 0,
  parameter int unsigned MAX_RETRIES   = 3,
  parameter int unsigned GAP_CYCLES    = 16,
  parameter bit          AUTO_START    = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  output logic [31:0] id_value,
  output logic [31:0] timestamp_value,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_stale,
  output logic [3:0]  retry_count
);
  localparam logic [7:0] LAT  = 8'(READ_LATENCY);
  localparam logic [7:0] GAP  = 8'(GAP_CYCLES);
  localparam logic [3:0] MAXR = 4'(MAX_RETRIES);
  localparam bit         LAT0 = READ_LATENCY == 0;
  state_t      r_state, w_next;
  logic [31:0] r_id_value, r_ts_value;
  logic        r_done, r_pass, r_id_mm, r_ts_stale, r_first;
  logic [3:0]  r_retry;
  logic        w_launch, w_cap_id, w_cap_ts, w_gap_load, w_check, w_ok, w_lat_load;
  logic [7:0]  w_lat_count, w_gap_count;
  logic        w_lat_zero, w_gap_zero;
  assign w_ok       = (r_id_value == EXPECTED_ID) && (r_ts_value >= MIN_TIMESTAMP);
  assign w_lat_load = (r_state == S_RD_ID) || (r_state == S_RD_TS);
  sonic_sysid_rd_timer u_lat (
    .clock(clock), .reset(reset), .i_load(w_lat_load), .i_value(LAT),
    .i_dec((r_state == S_WAIT_ID) || (r_state == S_WAIT_TS)),
    .o_count(w_lat_count), .o_zero(w_lat_zero)
  );
  sonic_sysid_rd_timer u_gap (
    .clock(clock), .reset(reset), .i_load(w_gap_load), .i_value(GAP),
    .i_dec(r_state == S_GAP), .o_count(w_gap_count), .o_zero(w_gap_zero)
  );
  // WAIT_ID always spends one cycle at count zero: that is the mandatory spacing before the TS strobe.
  always_comb begin
    w_next     = r_state;
    w_launch   = 1'b0;
    w_cap_id   = 1'b0;
    w_cap_ts   = 1'b0;
    w_gap_load = 1'b0;
    w_check    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_launch = start || (AUTO_START && r_first);
        w_next   = w_launch ? S_RD_ID : S_IDLE;
      end
      S_RD_ID: begin
        w_cap_id = LAT0;
        w_next   = S_WAIT_ID;
      end
      S_WAIT_ID: begin
        w_cap_id = w_lat_count == 8'd1;
        w_next   = w_lat_zero ? S_RD_TS : S_WAIT_ID;
      end
      S_RD_TS: begin
        w_cap_ts = LAT0;
        w_next   = LAT0 ? S_CHECK : S_WAIT_TS;
      end
      S_WAIT_TS: begin
        w_cap_ts = w_lat_count == 8'd1;
        w_next   = (w_cap_ts || w_lat_zero) ? S_CHECK : S_WAIT_TS;
      end
      S_CHECK: begin
        w_check    = 1'b1;
        w_gap_load = !w_ok && (r_retry < MAXR);
        w_next     = w_gap_load ? S_GAP : S_DONE;
      end
      S_GAP: w_next = (w_gap_count == 8'd1 || w_gap_zero) ? S_RD_ID : S_GAP;
      S_DONE: begin
        w_launch = start;
        w_next   = start ? S_RD_ID : S_DONE;
      end
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_first    <= 1'b1;
      r_id_value <= '0;
      r_ts_value <= '0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_id_mm    <= 1'b0;
      r_ts_stale <= 1'b0;
      r_retry    <= '0;
    end else begin
      r_state <= w_next;
      r_first <= 1'b0;
      if (w_cap_id) r_id_value <= avm_readdata;
      if (w_cap_ts) r_ts_value <= avm_readdata;
      if (w_launch) begin
        r_retry    <= '0;
        r_done     <= 1'b0;
        r_pass     <= 1'b0;
        r_id_mm    <= 1'b0;
        r_ts_stale <= 1'b0;
      end
      if (w_check) begin
        r_id_mm    <= r_id_value != EXPECTED_ID;
        r_ts_stale <= r_ts_value < MIN_TIMESTAMP;
        r_pass     <= w_ok;
        r_done     <= !w_gap_load;
        if (w_gap_load) r_retry <= r_retry + 4'd1;
      end
    end
  end
  assign avm_read        = (r_state == S_RD_ID) || (r_state == S_RD_TS);
  assign avm_address     = (r_state == S_RD_TS || r_state == S_WAIT_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
  assign busy            = !(r_state == S_IDLE || r_state == S_DONE);
  assign id_value        = r_id_value;
  assign timestamp_value = r_ts_value;
  assign done            = r_done;
  assign pass            = r_pass;
  assign id_mismatch     = r_id_mm;
  assign ts_stale        = r_ts_stale;
  assign retry_count     = r_retry;
endmodule

// File: tb/tb_sonic_sysid_checker.sv
// tb_sonic_sysid_checker: directed checks of three checker instances (L=0, L=2, MIN_TIMESTAMP=100).
module tb_sonic_sysid_checker;
  localparam logic [31:0] GOOD_ID = 32'h38D8FF5B;
  localparam logic [31:0] JUNK    = 32'hBAD0BAD0;
  logic clock = 1'b0, reset = 1'b1;
  logic start0 = 1'b0, start2 = 1'b0, starts = 1'b0;
  logic [31:0] wid0 = GOOD_ID, wts0 = 32'd1, wid2 = GOOD_ID, wts2 = 32'd1, wids = GOOD_ID, wtss = 32'd50;
  logic rd0, ad0, busy0, done0, pass0, mm0, st0;
  logic rd2, ad2, busy2, done2, pass2, mm2, st2;
  logic rds, ads, busys, dones, passs, mms, sts;
  logic [31:0] rdata0, rdata2, rdatas, idv0, tsv0, idv2, tsv2, idvs, tsvs;
  logic [3:0] rc0, rc2, rcs;
  logic [1:0] p1 = 2'b00, p2 = 2'b00;
  int n_chk = 0, n_fail = 0, n_rd0 = 0, n_rd2 = 0;
  always #5 clock = ~clock;
  assign rdata0 = rd0 ? (ad0 ? wts0 : wid0) : JUNK;
  assign rdatas = rds ? (ads ? wtss : wids) : JUNK;
  always @(posedge clock) begin
    p1 <= {rd2, ad2};
    p2 <= p1;
  end
  assign rdata2 = p2[1] ? (p2[0] ? wts2 : wid2) : JUNK;
  always @(negedge clock) begin
    if (rd0) n_rd0++;
    if (rd2) n_rd2++;
  end
  sonic_sysid_checker #(.MIN_TIMESTAMP(32'd0), .READ_LATENCY(0), .MAX_RETRIES(3), .GAP_CYCLES(16), .AUTO_START(1'b1)) dut0 (
    .clock(clock), .reset(reset), .start(start0), .avm_address(ad0), .avm_read(rd0), .avm_readdata(rdata0),
    .id_value(idv0), .timestamp_value(tsv0), .busy(busy0), .done(done0), .pass(pass0),
    .id_mismatch(mm0), .ts_stale(st0), .retry_count(rc0));
  sonic_sysid_checker #(.MIN_TIMESTAMP(32'd0), .READ_LATENCY(2), .MAX_RETRIES(3), .GAP_CYCLES(16), .AUTO_START(1'b1)) dut2 (
    .clock(clock), .reset(reset), .start(start2), .avm_address(ad2), .avm_read(rd2), .avm_readdata(rdata2),
    .id_value(idv2), .timestamp_value(tsv2), .busy(busy2), .done(done2), .pass(pass2),
    .id_mismatch(mm2), .ts_stale(st2), .retry_count(rc2));
  sonic_sysid_checker #(.MIN_TIMESTAMP(32'd100), .READ_LATENCY(0), .MAX_RETRIES(3), .GAP_CYCLES(16), .AUTO_START(1'b1)) duts (
    .clock(clock), .reset(reset), .start(starts), .avm_address(ads), .avm_read(rds), .avm_readdata(rdatas),
    .id_value(idvs), .timestamp_value(tsvs), .busy(busys), .done(dones), .pass(passs),
    .id_mismatch(mms), .ts_stale(sts), .retry_count(rcs));
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // {avm_read, avm_address, busy, done} per cycle after launch for dut0 and dut2
  typedef struct packed {
    logic [3:0] e0;
    logic [3:0] e2;
  } vec_t;
  vec_t tbl [10];
  int kd, base;
  initial begin
    tbl[0] = '{4'b1010, 4'b1010};
    tbl[1] = '{4'b0010, 4'b0010};
    tbl[2] = '{4'b1110, 4'b0010};
    tbl[3] = '{4'b0010, 4'b0010};
    tbl[4] = '{4'b0001, 4'b1110};
    tbl[5] = '{4'b0001, 4'b0110};
    tbl[6] = '{4'b0001, 4'b0110};
    tbl[7] = '{4'b0001, 4'b0010};
    tbl[8] = '{4'b0001, 4'b0001};
    tbl[9] = '{4'b0001, 4'b0001};
    repeat (3) @(negedge clock);
    chk("reset_state", {rd0, ad0, idv0, tsv0, busy0, done0, pass0, mm0, st0, rc0}, '0);
    reset = 1'b0;
    @(negedge clock);
    for (int c = 0; c < 25; c++) begin
      if (c > 0) @(negedge clock);
      if (c < 10) begin
        chk($sformatf("tbl_dut0_c%0d", c), {rd0, ad0, busy0, done0}, tbl[c].e0);
        chk($sformatf("tbl_dut2_c%0d", c), {rd2, ad2, busy2, done2}, tbl[c].e2);
      end
      if (c == 2) chk("lat2_id_not_early", idv2, 32'd0);
      if (c == 3) chk("lat2_id_capture", idv2, GOOD_ID);
      if (c == 6) chk("lat2_ts_not_early", tsv2, 32'd0);
      if (c == 7) chk("lat2_ts_capture", tsv2, 32'd1);
      if (c == 8) chk("lat2_result", {pass2, mm2, st2, rc2}, {3'b100, 4'd0});
      if (c == 4) chk("pass_result", {pass0, mm0, st0, rc0, idv0, tsv0}, {3'b100, 4'd0, GOOD_ID, 32'd1});
      if (c == 4) begin
        chk("stale_first_check", {sts, mms, rcs, dones, passs}, {2'b10, 4'd1, 2'b00});
        wtss = 32'd200;
      end
      if (c == 10) chk("stale_gap_busy", {busys, dones}, 2'b10);
      if (c == 23) chk("stale_not_done_yet", dones, 1'b0);
      if (c == 24) chk("stale_recovered", {dones, passs, sts, mms, rcs}, {4'b1100, 4'd1});
    end
    chk("pass_strobe_count", n_rd0, 2);
    chk("lat2_strobe_count", n_rd2, 2);
    // ID mismatch until retries run out, with start pulses while busy that must be ignored
    wid0 = 32'hDEADBEEF;
    base = n_rd0;
    start0 = 1'b1;
    @(negedge clock);
    start0 = 1'b0;
    chk("restart_from_done", {rd0, ad0, busy0, done0, pass0, mm0, rc0}, {3'b101, 3'b000, 4'd0});
    kd = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clock);
      start0 = (k == 21 || k == 30);
      if (k == 5) chk("mm_first_gap", {mm0, rc0, done0, busy0}, {1'b1, 4'd1, 2'b01});
      if (k == 10) chk("mm_gap_busy", {busy0, rd0}, 2'b10);
      if (done0 && kd < 0) kd = k;
    end
    chk("mm_done_cycle", kd, 64);
    chk("mm_strobe_count", n_rd0 - base, 8);
    chk("mm_result", {done0, pass0, mm0, st0, rc0}, {4'b1010, 4'd3});
    wid0 = GOOD_ID;
    base = n_rd0;
    start0 = 1'b1;
    @(negedge clock);
    start0 = 1'b0;
    chk("restart_flags_cleared", {done0, pass0, mm0, st0, rc0, busy0, rd0}, {4'b0000, 4'd0, 2'b11});
    kd = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (done0 && kd < 0) kd = k;
    end
    chk("restart_done_cycle", kd, 4);
    chk("restart_result", {pass0, mm0, rc0, n_rd0 - base}, {2'b10, 4'd0, 32'd2});
    // reset during WAIT_TS of the latency-2 instance
    start2 = 1'b1;
    @(negedge clock);
    start2 = 1'b0;
    repeat (5) @(negedge clock);
    chk("in_wait_ts", {rd2, ad2, busy2, done2}, 4'b0110);
    reset = 1'b1;
    @(negedge clock);
    chk("reset_mid_seq", {rd2, ad2, idv2, tsv2, busy2, done2, pass2, mm2, st2, rc2}, '0);
    reset = 1'b0;
    @(negedge clock);
    chk("auto_relaunch", {rd2, ad2, busy2}, 3'b101);
    kd = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (done2 && kd < 0) kd = k;
    end
    chk("relaunch_done_cycle", kd, 8);
    chk("relaunch_result", {pass2, idv2, tsv2}, {1'b1, GOOD_ID, 32'd1});
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
